bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles from grant to first master_valid before the grant is revoked.
REQ-002 SHALL have parameter SLAVE_COUNT, default 3: number of decoded slaves; select values >= SLAVE_COUNT are invalid.
REQ-003 clk  input  1  single bus clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m1_request  input  1  master 1 requests the bus; held high until its transaction completes.
REQ-006 m2_request  input  1  master 2 requests the bus; same rules as m1_request.
REQ-007 master_valid  input  1  muxed valid of the granted master; a serial bit is present on bus_serial.
REQ-008 bus_serial  input  1  muxed serial address/data line of the granted master, MSB first.
REQ-009 m1_grant  output  1  bus owned by master 1.
REQ-010 m2_grant  output  1  bus owned by master 2.
REQ-011 slave_sel  output  2  decoded target slave index.
REQ-012 slave_sel_valid  output  1  slave_sel is stable; slave read_en/write_en routing is enabled.
REQ-013 bus_busy  output  1  high in any state other than IDLE.
REQ-014 addr_err  output  1  one-cycle pulse: invalid slave select or grant timeout.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, ADDR, CONNECT, RELEASE.
REQ-016 IDLE: no request -> stay; one request -> assert that grant, go GRANT on the next cycle; both requests -> grant the master that did not own the last completed tenure (round-robin); the first contention after reset goes to master 1.
REQ-017 Grant SHALL be registered; m1_grant and m2_grant SHALL never be high together.
REQ-018 GRANT: master_valid high -> capture bus_serial as select MSB, go ADDR; otherwise increment the wait counter.
REQ-019 When the wait counter reaches TIMEOUT-1 in GRANT without master_valid: pulse addr_err, drop the grant, go RELEASE.
REQ-020 ADDR: on the next master_valid, capture the select LSB into slave_sel.
REQ-021 ADDR, after LSB capture: select < SLAVE_COUNT -> go CONNECT, slave_sel_valid high from the next cycle; otherwise pulse addr_err, drop the grant, go RELEASE.
REQ-022 ADDR: master_valid low stalls without timeout; the granted request dropping -> RELEASE, no error.
REQ-023 CONNECT: hold the grant and slave_sel; exit to RELEASE when the granted master deasserts its request.
REQ-024 RELEASE: lasts exactly one cycle; grants, slave_sel_valid and the wait counter are cleared; record the last owner; go IDLE.
REQ-025 A granted request dropping in GRANT SHALL go to RELEASE with no addr_err.
REQ-026 The other master's request SHALL never preempt an active tenure; it is served at the next IDLE.
REQ-027 Back-to-back tenures: minimum two cycles between one master's grant deassertion and the next grant assertion (RELEASE + IDLE).
REQ-028 slave_sel SHALL hold its last value after slave_sel_valid falls.
REQ-029 The wait counter SHALL be clog2(TIMEOUT) bits wide and SHALL saturate, never wrap.

Reset
REQ-030 reset low SHALL force state IDLE asynchronously.
REQ-031 reset low SHALL clear all outputs to 0, the wait counter to 0, and the last owner to master 2, so master 1 wins the first contention.
REQ-032 Reset mid-tenure SHALL drop the grant immediately; the first post-reset decision uses the REQ-031 values.

Structure
REQ-033 A shared bus package SHALL hold the FSM state encoding, the slave-select width (2), and the TIMEOUT/SLAVE_COUNT defaults.
REQ-034 The round-robin decision SHALL be a sub-module, rr_priority_2: inputs 2 requests and last owner, output a one-hot winner; purely combinational.

Verification
REQ-035 m1_request only, serial select 1,0 -> m1_grant one cycle after request, slave_sel=2, slave_sel_valid high; m1_request drop -> RELEASE, grant low.
REQ-036 Both requests held high after reset -> m1 granted first; m1 drops -> m2 granted exactly 2 cycles after m1_grant falls.
REQ-037 m2 granted, master_valid held low for 16 cycles -> addr_err single pulse, m2_grant low, bus_busy low 2 cycles later.
REQ-038 Serial select 1,1 with SLAVE_COUNT=3 -> addr_err pulse, slave_sel_valid never high, grant released.
REQ-039 reset pulled low during CONNECT -> all outputs 0 in the same cycle, no clock needed; after release with both requests high -> m1 granted.
REQ-040 m2_request asserted during m1 CONNECT -> m1 tenure undisturbed, m2 granted after m1 releases.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master serial-select bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StAddr,
    StConnect,
    StRelease
  } state_e;

  localparam int unsigned SelW          = 2;
  localparam int unsigned DefTimeout    = 16;
  localparam int unsigned DefSlaveCount = 3;

endpackage

// File: rtl/rr_priority_2.sv
// Two-way round-robin pick: a lone requester wins; on contention the master
// that did not own the last tenure wins.
module rr_priority_2 (
  input  logic [1:0] req_i,   // bit 0 = master 1, bit 1 = master 2
  input  logic       last_i,  // 1: master 2 owned the last completed tenure
  output logic [1:0] win_o
);

  always_comb begin
    win_o = req_i;
    if (&req_i) begin
      win_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: grants the bus, shifts in a 2-bit serial slave
// select, routes to the slave until the owner drops its request.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT     = DefTimeout,
  parameter int unsigned SLAVE_COUNT = DefSlaveCount
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m1_request,
  input  logic            m2_request,
  input  logic            master_valid,
  input  logic            bus_serial,
  output logic            m1_grant,
  output logic            m2_grant,
  output logic [SelW-1:0] slave_sel,
  output logic            slave_sel_valid,
  output logic            bus_busy,
  output logic            addr_err
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] WaitMax = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            owner_q, owner_d;  // 1: master 2 holds the current tenure
  logic            last_q, last_d;    // 1: master 2 held the last tenure
  logic [CntW-1:0] wait_q, wait_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic            sel_valid_q, sel_valid_d;
  logic            err_q, err_d;

  logic [1:0]      win;
  logic            owner_req;
  logic [SelW-1:0] sel_cand;
  logic            sel_ok;

  rr_priority_2 u_rr (
    .req_i  ({m2_request, m1_request}),
    .last_i (last_q),
    .win_o  (win)
  );

  assign owner_req = owner_q ? m2_request : m1_request;
  assign sel_cand  = {sel_q[1], bus_serial};
  assign sel_ok    = 32'(sel_cand) < SLAVE_COUNT;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wait_d      = wait_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|win) begin
          grant_d = win;
          owner_d = win[1];
          wait_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = StRelease;
        end else if (master_valid) begin
          sel_d[1] = bus_serial;
          wait_d   = '0;
          state_d  = StAddr;
        end else if (wait_q == WaitMax) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = StRelease;
        end else if (wait_q != '1) begin
          wait_d = wait_q + CntW'(1);
        end
      end
      StAddr: begin
        // A stalled master (valid low) may sit here indefinitely.
        if (!owner_req) begin
          grant_d = '0;
          state_d = StRelease;
        end else if (master_valid) begin
          sel_d[0] = bus_serial;
          if (sel_ok) begin
            sel_valid_d = 1'b1;
            state_d     = StConnect;
          end else begin
            err_d   = 1'b1;
            grant_d = '0;
            state_d = StRelease;
          end
        end
      end
      StConnect: begin
        if (!owner_req) begin
          grant_d     = '0;
          sel_valid_d = 1'b0;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        grant_d     = '0;
        sel_valid_d = 1'b0;
        wait_d      = '0;
        last_d      = owner_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      wait_q      <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      err_q       <= err_d;
    end
  end

  assign m1_grant        = grant_q[0];
  assign m2_grant        = grant_q[1];
  assign slave_sel       = sel_q;
  assign slave_sel_valid = sel_valid_q;
  assign bus_busy        = (state_q != StIdle);
  assign addr_err        = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corner
// sequences, and randomized tenures against a transaction-level model.
module tb_bus_arbiter;

  localparam int unsigned To = 16;
  localparam int unsigned Sc = 3;

  logic       clk;
  logic       reset;
  logic       m1_request, m2_request, master_valid, bus_serial;
  logic       m1_grant, m2_grant, slave_sel_valid, bus_busy, addr_err;
  logic [1:0] slave_sel;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(
    .TIMEOUT     (To),
    .SLAVE_COUNT (Sc)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m1_request      (m1_request),
    .m2_request      (m2_request),
    .master_valid    (master_valid),
    .bus_serial      (bus_serial),
    .m1_grant        (m1_grant),
    .m2_grant        (m2_grant),
    .slave_sel       (slave_sel),
    .slave_sel_valid (slave_sel_valid),
    .bus_busy        (bus_busy),
    .addr_err        (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector is {m1_grant, m2_grant, slave_sel_valid, addr_err, bus_busy}.
  task automatic chk_vec(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {m1_grant, m2_grant, slave_sel_valid, addr_err, bus_busy};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: outputs g1,g2,ssv,err,busy got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_sel(input string name, input logic [1:0] exp);
    checks++;
    if (slave_sel !== exp) begin
      failures++;
      $display("FAIL %s: slave_sel got %0d expected %0d", name, slave_sel, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m1_request = 1'b0; m2_request = 1'b0; master_valid = 1'b0; bus_serial = 1'b0;
    repeat (2) @(negedge clk);
    chk_vec("reset_outputs", 5'b00000);
    chk_sel("reset_sel", 2'd0);
    reset = 1'b1;
  endtask

  // One full tenure driven as the granted master; starts and ends in IDLE.
  task automatic run_tenure(input bit r1, input bit r2, input int d, input logic [1:0] sel,
                            input int stall, input int hold, input int exp_win,
                            input bit exp_err, input string tag);
    logic [1:0] g;
    g = (exp_win == 1) ? 2'b10 : 2'b01;
    m1_request = r1; m2_request = r2; master_valid = 1'b0; bus_serial = 1'b0;
    @(negedge clk);
    chk_vec($sformatf("%s grant", tag), {g, 3'b001});
    if (d >= int'(To)) begin
      for (int i = 1; i < int'(To); i++) @(negedge clk);
      chk_vec($sformatf("%s last_wait", tag), {g, 3'b001});
      @(negedge clk);
      chk_vec($sformatf("%s timeout", tag), 5'b00011);
      m1_request = 1'b0; m2_request = 1'b0;
      @(negedge clk);
      chk_vec($sformatf("%s idle", tag), 5'b00000);
    end else begin
      repeat (d) @(negedge clk);
      master_valid = 1'b1; bus_serial = sel[1];
      @(negedge clk);
      master_valid = 1'b0; bus_serial = 1'($urandom);
      repeat (stall) @(negedge clk);
      chk_vec($sformatf("%s addr", tag), {g, 3'b001});
      master_valid = 1'b1; bus_serial = sel[0];
      @(negedge clk);
      master_valid = 1'b0;
      if (exp_err) begin
        chk_vec($sformatf("%s sel_err", tag), 5'b00011);
        m1_request = 1'b0; m2_request = 1'b0;
        @(negedge clk);
        chk_vec($sformatf("%s idle", tag), 5'b00000);
      end else begin
        chk_vec($sformatf("%s connect", tag), {g, 3'b101});
        chk_sel($sformatf("%s sel", tag), sel);
        repeat (hold) @(negedge clk);
        chk_vec($sformatf("%s hold", tag), {g, 3'b101});
        m1_request = 1'b0; m2_request = 1'b0;
        @(negedge clk);
        chk_vec($sformatf("%s release", tag), 5'b00001);
        chk_sel($sformatf("%s sel_kept", tag), sel);
        @(negedge clk);
        chk_vec($sformatf("%s idle", tag), 5'b00000);
      end
    end
  endtask

  // Serial select into CONNECT for master 1 only.
  task automatic m1_to_connect(input logic [1:0] sel, input string tag);
    m1_request = 1'b1;
    @(negedge clk);
    chk_vec($sformatf("%s grant", tag), 5'b10001);
    master_valid = 1'b1; bus_serial = sel[1];
    @(negedge clk);
    bus_serial = sel[0];
    @(negedge clk);
    master_valid = 1'b0;
    chk_vec($sformatf("%s connect", tag), 5'b10101);
    chk_sel($sformatf("%s sel", tag), sel);
  endtask

  typedef struct {
    bit         r1;
    bit         r2;
    int         d;
    logic [1:0] sel;
    int         stall;
    int         hold;
    int         exp_win;
    bit         exp_err;
  } vec_t;

  vec_t tbl[8];
  int   last_owner;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 0,  2'd2, 0,  2, 1, 1'b0};  // lone m1, select 2
    tbl[1] = '{1'b1, 1'b1, 1,  2'd0, 2,  1, 2, 1'b0};  // contention after m1 -> m2
    tbl[2] = '{1'b1, 1'b1, 15, 2'd1, 0,  0, 1, 1'b0};  // valid on the last allowed cycle
    tbl[3] = '{1'b0, 1'b1, 16, 2'd0, 0,  0, 2, 1'b1};  // grant timeout
    tbl[4] = '{1'b1, 1'b1, 0,  2'd3, 0,  0, 1, 1'b1};  // select 3 is invalid
    tbl[5] = '{1'b1, 1'b1, 0,  2'd2, 20, 1, 2, 1'b0};  // long ADDR stall, no timeout
    tbl[6] = '{1'b0, 1'b1, 2,  2'd1, 1,  3, 2, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 3,  2'd0, 0,  0, 1, 1'b0};

    do_reset();
    foreach (tbl[i]) begin
      run_tenure(tbl[i].r1, tbl[i].r2, tbl[i].d, tbl[i].sel, tbl[i].stall, tbl[i].hold,
                 tbl[i].exp_win, tbl[i].exp_err, $sformatf("vec%0d", i));
    end

    // First contention after reset goes to m1; m2 follows two cycles after m1 drops.
    do_reset();
    m1_request = 1'b1; m2_request = 1'b1;
    @(negedge clk);
    chk_vec("rr_first m1_grant", 5'b10001);
    master_valid = 1'b1; bus_serial = 1'b0;
    @(negedge clk);
    bus_serial = 1'b1;
    @(negedge clk);
    master_valid = 1'b0;
    chk_vec("rr_first connect", 5'b10101);
    m1_request = 1'b0;
    @(negedge clk);
    chk_vec("rr_first release", 5'b00001);
    @(negedge clk);
    chk_vec("rr_first gap", 5'b00000);
    @(negedge clk);
    chk_vec("rr_first m2_grant", 5'b01001);
    m2_request = 1'b0;  // drop while in GRANT: release without error
    @(negedge clk);
    chk_vec("grant_drop release", 5'b00001);
    @(negedge clk);
    chk_vec("grant_drop idle", 5'b00000);

    // Reset during CONNECT clears outputs without a clock and restores m1 priority.
    run_tenure(1'b1, 1'b0, 0, 2'd0, 0, 0, 1, 1'b0, "pre_rst");
    m1_to_connect(2'd2, "rst_mid");
    #2 reset = 1'b0;
    #1;
    chk_vec("async_reset outputs", 5'b00000);
    chk_sel("async_reset sel", 2'd0);
    m1_request = 1'b1; m2_request = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_vec("post_reset m1_first", 5'b10001);
    m1_request = 1'b0; m2_request = 1'b0;
    repeat (2) @(negedge clk);
    chk_vec("post_reset idle", 5'b00000);

    // m2 arriving mid-tenure waits for m1 to finish.
    m1_to_connect(2'd1, "nopreempt");
    m2_request = 1'b1;
    repeat (3) @(negedge clk);
    chk_vec("nopreempt hold", 5'b10101);
    chk_sel("nopreempt sel", 2'd1);
    m1_request = 1'b0;
    @(negedge clk);
    chk_vec("nopreempt release", 5'b00001);
    @(negedge clk);
    chk_vec("nopreempt gap", 5'b00000);
    @(negedge clk);
    chk_vec("nopreempt m2_grant", 5'b01001);
    m2_request = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized tenures against the transaction-level model.
    do_reset();
    last_owner = 2;
    for (int n = 0; n < 40; n++) begin
      int         rq, d, stall, hold, win;
      logic [1:0] sel;
      bit         r1, r2, err;
      rq    = int'($urandom_range(1, 3));
      r1    = rq[0];
      r2    = rq[1];
      d     = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, To + 3));
      sel   = 2'($urandom_range(0, 3));
      stall = int'($urandom_range(0, 3));
      hold  = int'($urandom_range(0, 3));
      if (r1 && r2) win = (last_owner == 1) ? 2 : 1;
      else          win = r1 ? 1 : 2;
      err = (d >= int'(To)) || (int'(sel) >= int'(Sc));
      last_owner = win;
      run_tenure(r1, r2, d, sel, stall, hold, win, err, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
